// File: rtl/weight_buffer_pkg.sv
// weight_buffer_pkg: shared FSM encoding and load-command type for the weight buffer fill/read sequencers
package weight_buffer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;
  localparam int CMD_ADDR_WIDTH = 5;
  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0] base_addr;
    logic [CMD_ADDR_WIDTH:0]   num_words;
  } load_cmd_t;
endpackage

// File: rtl/weight_lane_swap.sv
// weight_lane_swap: reverses the order of RD_WIDTH-bit lanes within a WR_WIDTH-bit word
module weight_lane_swap #(
  parameter int WR_WIDTH = 64,
  parameter int RD_WIDTH = 16
) (
  input  logic [WR_WIDTH-1:0] data_i,
  output logic [WR_WIDTH-1:0] data_o
);
  localparam int LANES = WR_WIDTH / RD_WIDTH;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign data_o[i*RD_WIDTH +: RD_WIDTH] = data_i[(LANES-1-i)*RD_WIDTH +: RD_WIDTH];
  end
endmodule

// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader: turns a valid/ready weight stream into registered buffer writes; lane reversal under WEIGHT_LOADER_LANE_SWAP_EN
module weight_buffer_loader
  import weight_buffer_pkg::*;
#(
  parameter int WR_WIDTH      = 64,
  parameter int RD_WIDTH      = 16,
  parameter int WR_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_start,
  input  logic [WR_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [WR_ADDR_WIDTH:0]   cfg_num_words,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WR_WIDTH-1:0]      s_data,
  output logic                     write_req,
  output logic [WR_ADDR_WIDTH-1:0] write_addr,
  output logic [WR_WIDTH-1:0]      write_data,
  output logic                     busy,
  output logic                     done
);
  state_e                   state_q, state_d;
  logic [WR_ADDR_WIDTH-1:0] addr_q, addr_d, write_addr_q;
  logic [WR_ADDR_WIDTH:0]   remain_q, remain_d;
  logic [WR_WIDTH-1:0]      write_data_q, lane_data;
  logic                     write_req_q, accept;
`ifdef WEIGHT_LOADER_LANE_SWAP_EN
  weight_lane_swap #(.WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH)) u_swap (
    .data_i(s_data),
    .data_o(lane_data)
  );
`else
  assign lane_data = s_data;
`endif
  assign s_ready = state_q == LOAD;
  assign accept  = s_ready && s_valid;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: if (cfg_start) begin
        state_d  = cfg_num_words == '0 ? DONE : LOAD;
        addr_d   = cfg_base_addr;
        remain_d = cfg_num_words;
      end
      LOAD: if (accept) begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = remain_q == 1 ? FLUSH : LOAD;
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      write_req_q  <= accept;
      write_addr_q <= accept ? addr_q : write_addr_q;
      write_data_q <= accept ? lane_data : write_data_q;
    end
  end
  assign write_req  = write_req_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
endmodule

// File: tb/tb_weight_buffer_loader.sv
// tb_weight_buffer_loader: table-driven loads with a write scoreboard, plus zero-count, mid-load start and reset-abort sequences
module tb_weight_buffer_loader;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cfg_start = 1'b0, s_valid = 1'b0;
  logic [4:0]  cfg_base_addr = '0;
  logic [5:0]  cfg_num_words = '0;
  logic [63:0] s_data = '0;
  logic        s_ready, write_req, busy, done;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  int total = 0, bad = 0, nwr = 0;

  typedef struct {logic [4:0] a; logic [63:0] d;} wr_t;
  typedef struct {logic [4:0] base; logic [5:0] cnt; bit tog; bit mid; logic [63:0] seed;} vec_t;
  wr_t  q[$];
  wr_t  e_m;
  vec_t v[6];

  weight_buffer_loader dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_words(cfg_num_words), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, x, $time);
    end
  endtask

  function automatic logic [63:0] xd(input logic [63:0] d);
`ifdef WEIGHT_LOADER_LANE_SWAP_EN
    for (int i = 0; i < 4; i++) xd[i*16 +: 16] = d[(3-i)*16 +: 16];
`else
    xd = d;
`endif
  endfunction

  always @(negedge clk) if (write_req === 1'b1) begin
    nwr++;
    if (q.size() == 0) chk("unexpected_write", 1, 0);
    else begin
      e_m = q.pop_front();
      chk("write_addr", write_addr, e_m.a);
      chk("write_data", write_data, e_m.d);
    end
  end

  task automatic run_load(input vec_t t);
    int k = 0, cyc = 0;
    logic [4:0] a = t.base;
    nwr = 0;
    cfg_base_addr = t.base; cfg_num_words = t.cnt; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    if (t.cnt == 0) begin
      chk("zero_ready", s_ready, 0); chk("zero_busy", busy, 1); chk("zero_done", done, 1);
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      chk("zero_idle_busy", busy, 0); chk("zero_idle_done", done, 0); chk("zero_ready2", s_ready, 0);
      @(negedge clk);
      chk("zero_writes", nwr, 0);
      return;
    end
    while (k < t.cnt && cyc < 200) begin
      chk("ready_load", s_ready, 1); chk("busy_load", busy, 1); chk("done_load", done, 0);
      s_valid = t.tog ? (cyc % 2 == 0) : 1'b1;
      s_data = t.seed + 64'(k);
      cfg_start = t.mid && k == 10;
      if (cfg_start) begin cfg_base_addr = 5'd17; cfg_num_words = 6'd3; end
      if (s_valid) begin q.push_back('{a, xd(s_data)}); a++; k++; end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    chk("beats_accepted", k, t.cnt);
    s_data = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("flush_ready", s_ready, 0); chk("flush_busy", busy, 1); chk("flush_done", done, 0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("done_pulse", done, 1); chk("done_busy", busy, 1); chk("done_ready", s_ready, 0);
    @(negedge clk);
    chk("idle_done", done, 0); chk("idle_busy", busy, 0);
    chk("queue_empty", q.size(), 0); chk("write_count", nwr, t.cnt);
  endtask

  initial begin
    v[0] = '{5'd0,  6'd4,  1'b0, 1'b0, 64'h0000_0000_0000_0001};
    v[1] = '{5'd30, 6'd4,  1'b1, 1'b0, 64'hA5A5_0000_0000_0010};
    v[2] = '{5'd0,  6'd0,  1'b0, 1'b0, 64'h0};
    v[3] = '{5'd5,  6'd32, 1'b0, 1'b1, 64'h0123_4567_89AB_0000};
    v[4] = '{5'd9,  6'd1,  1'b0, 1'b0, 64'h1111_2222_3333_4444};
    v[5] = '{5'd31, 6'd3,  1'b1, 1'b0, 64'hFFFF_0000_FFFF_FF00};
    #1;
    chk("rst_ready", s_ready, 0); chk("rst_wreq", write_req, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_waddr", write_addr, 0); chk("rst_wdata", write_data, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_load(v[i]);
    // abort a 6-beat load after two accepted beats
    nwr = 0;
    cfg_base_addr = 5'd3; cfg_num_words = 6'd6; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = 64'h7700 + 64'(k);
      q.push_back('{5'(3 + k), xd(s_data)});
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ready", s_ready, 0); chk("abort_wreq", write_req, 0); chk("abort_busy", busy, 0);
    chk("abort_done", done, 0); chk("abort_waddr", write_addr, 0); chk("abort_wdata", write_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_abort_done", done, 0); chk("post_abort_busy", busy, 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("abort_writes", nwr, 2); chk("abort_queue", q.size(), 0);
    run_load(v[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
